// File: rtl/spi_buf_slave_pkg.sv
// Shared command-byte layout and FSM encoding for the SPI buffer slave.
package spi_buf_slave_pkg;

  localparam int CMD_RD_BIT = 7;
  localparam int ADDR_W     = 7;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_WR   = 2'd2,
    S_RD   = 2'd3
  } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Synchronises SCK/CS_n/MOSI into clk with STAGES flops; SCK also gets
// one-clk rise/fall events (valid on the same clk as the synchronised MOSI).
module spi_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sck,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_n,
  output logic o_mosi
);

  logic [STAGES-1:0] r_sck_sync;
  logic [STAGES-1:0] r_cs_sync;
  logic [STAGES-1:0] r_mosi_sync;
  logic              r_sck_prev;

  // cs_n resets deasserted so a frame can only start after a real falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[STAGES-2:0], i_sck};
      r_cs_sync   <= {r_cs_sync[STAGES-2:0], i_cs_n};
      r_mosi_sync <= {r_mosi_sync[STAGES-2:0], i_mosi};
      r_sck_prev  <= r_sck_sync[STAGES-1];
    end
  end

  assign o_sck_rise = r_sck_sync[STAGES-1] & ~r_sck_prev;
  assign o_sck_fall = ~r_sck_sync[STAGES-1] & r_sck_prev;
  assign o_cs_n     = r_cs_sync[STAGES-1];
  assign o_mosi     = r_mosi_sync[STAGES-1];

endmodule

// File: rtl/spi_buf_slave.sv
// SPI mode-0 slave: command byte selects read/write at an auto-incrementing
// 7-bit address; writes pulse wr_stb SYNC_STAGES+1 clks after the 8th SCK rise.
module spi_buf_slave
  import spi_buf_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso_buf,
  output logic       wr_stb,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_stb,
  output logic [6:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       frame_err
);

  logic w_sck_rise, w_sck_fall, w_cs_n_s, w_mosi_s;

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_sck      (sck),
    .i_cs_n     (cs_n),
    .i_mosi     (mosi),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_n     (w_cs_n_s),
    .o_mosi     (w_mosi_s)
  );

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_bit_cnt;
  logic [BYTE_W-2:0]   r_shift_in;
  logic [BYTE_W-1:0]   r_shift_out;
  logic [BYTE_W-1:0]   r_rd_hold;
  logic [1:0]          r_rd_cnt;
  logic                r_load_pend;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr_stb, r_rd_stb, r_frame_err;
  logic [ADDR_W-1:0]   r_wr_addr, r_rd_addr;
  logic [BYTE_W-1:0]   r_wr_data;

  logic                w_active, w_byte_done, w_cs_end, w_frame_err;
  logic [BYTE_W-1:0]   w_byte;

  assign w_active    = (r_state != S_IDLE);
  assign w_byte_done = w_active && w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_cs_end    = w_active && w_cs_n_s;
  assign w_byte      = {r_shift_in, w_mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE:  if (!w_cs_n_s) w_state_nxt = S_CMD;
      S_CMD:   if (w_byte_done) w_state_nxt = w_byte[CMD_RD_BIT] ? S_RD : S_WR;
      default: ;
    endcase
    // A byte finishing on the same clk as cs_n rising still counts as complete.
    if (w_cs_end) begin
      w_state_nxt = S_IDLE;
      w_frame_err = (r_bit_cnt != 3'd0) && !w_byte_done;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_rd_hold   <= '0;
      r_rd_cnt    <= '0;
      r_load_pend <= 1'b0;
      r_addr      <= '0;
      r_wr_stb    <= 1'b0;
      r_rd_stb    <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_addr   <= '0;
    end else begin
      r_wr_stb    <= 1'b0;
      r_rd_stb    <= 1'b0;
      r_frame_err <= w_frame_err;

      if (!w_active) begin
        r_bit_cnt   <= '0;
        r_shift_out <= '0;
        r_load_pend <= 1'b0;
      end else if (w_sck_rise) begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_shift_in <= w_byte[BYTE_W-2:0];
      end

      if (w_byte_done) begin
        case (r_state)
          S_CMD: begin
            if (w_byte[CMD_RD_BIT]) begin
              r_rd_stb    <= 1'b1;
              r_rd_addr   <= w_byte[ADDR_W-1:0];
              r_addr      <= w_byte[ADDR_W-1:0] + 7'd1;
              r_load_pend <= 1'b1;
            end else begin
              r_addr      <= w_byte[ADDR_W-1:0];
            end
          end
          S_WR: begin
            r_wr_stb  <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= w_byte;
            r_addr    <= r_addr + 7'd1;
          end
          S_RD: begin
            r_rd_stb    <= 1'b1;
            r_rd_addr   <= r_addr;
            r_addr      <= r_addr + 7'd1;
            r_load_pend <= 1'b1;
          end
          default: ;
        endcase
      end

      if ((r_state == S_RD) && w_sck_fall) begin
        if (r_load_pend) begin
          r_shift_out <= r_rd_hold;
          r_load_pend <= 1'b0;
        end else begin
          r_shift_out <= {r_shift_out[BYTE_W-2:0], 1'b0};
        end
      end

      if (w_cs_end) r_shift_out <= '0;

      if (r_rd_stb)             r_rd_cnt <= 2'(RD_LAT);
      else if (r_rd_cnt != '0)  r_rd_cnt <= r_rd_cnt - 2'd1;
      if (r_rd_cnt == 2'd1)     r_rd_hold <= rd_data;
    end
  end

  assign miso_buf  = r_shift_out[BYTE_W-1];
  assign wr_stb    = r_wr_stb;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign rd_stb    = r_rd_stb;
  assign rd_addr   = r_rd_addr;
  assign busy      = w_active;
  assign frame_err = r_frame_err;

endmodule
